// File: rtl/rv_multicycle_control.sv
// ---------------------------------------------------------------------------
// rv_multicycle_control
//
// Multi-cycle control FSM for the RV32I core. One instruction is in flight at
// a time and walks FETCH -> DECODE -> EXECUTE -> [MEM] -> [WB] -> FETCH.
// Every datapath write-enable and mux select is decoded here from the current
// state and the opcode latched in DECODE (op_q). Only the handshake-qualified
// strobes additionally look at imem_ready / dmem_ready / branch_taken.
//
// Parameters
//   RESET_TRAP    1: an illegal opcode parks the FSM in TRAP until reset
//                 0: an illegal opcode is skipped (PC+4, no writeback)
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   opcode[6:0]   in   instruction[6:0] from the decoder (sampled in DECODE)
//   branch_taken  in   branch comparator result, used in EXECUTE
//   imem_req      out  instruction fetch request
//   imem_ready    in   fetch data valid this cycle
//   dmem_req      out  data memory request
//   dmem_we       out  1 = store, 0 = load (qualified by dmem_req)
//   dmem_ready    in   data access complete this cycle
//   ir_we         out  latch instruction register
//   pc_we         out  update PC
//   pc_sel        out  0 = PC+4, 1 = PC+imm
//   reg_we        out  register-file write enable
//   wb_sel[1:0]   out  0 = ALU, 1 = memory, 2 = PC+4, 3 = immediate
//   alu_src_imm   out  ALU operand B: 0 = rs2, 1 = immediate
//   imm_type[2:0] out  0 = I, 1 = S, 2 = B, 3 = U, 4 = J
//   illegal       out  sticky illegal-opcode flag
//   instr_retired out  one-cycle pulse per completed instruction
//   state_dbg     out  current state encoding
// ---------------------------------------------------------------------------
module rv_multicycle_control #(
    parameter bit RESET_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    output logic       imem_req,
    input  logic       imem_ready,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ready,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_sel,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic       alu_src_imm,
    output logic [2:0] imm_type,
    output logic       illegal,
    output logic       instr_retired,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    state_t     state_q, state_d;
    logic [6:0] op_q, op_d;
    logic       illegal_q, illegal_d;

    // Opcode classification helpers shared by every state.
    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LUI, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL: is_legal = 1'b1;
            default:                                                  is_legal = 1'b0;
        endcase
    endfunction

    // R-type has no immediate; I is returned as a harmless default.
    function automatic logic [2:0] imm_type_of(input logic [6:0] op);
        case (op)
            OP_STORE:  imm_type_of = IMM_S;
            OP_BRANCH: imm_type_of = IMM_B;
            OP_LUI:    imm_type_of = IMM_U;
            OP_JAL:    imm_type_of = IMM_J;
            default:   imm_type_of = IMM_I;
        endcase
    endfunction

    // Operand B is the immediate for address generation and I-type ALU ops.
    function automatic logic uses_imm(input logic [6:0] op);
        case (op)
            OP_I, OP_LOAD, OP_STORE: uses_imm = 1'b1;
            default:                 uses_imm = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] wb_sel_of(input logic [6:0] op);
        case (op)
            OP_LOAD: wb_sel_of = WB_MEM;
            OP_LUI:  wb_sel_of = WB_IMM;
            OP_JAL:  wb_sel_of = WB_PC4;
            default: wb_sel_of = WB_ALU;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= 7'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        illegal_d     = illegal_q;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        pc_sel        = 1'b0;
        reg_we        = 1'b0;
        wb_sel        = WB_ALU;
        alu_src_imm   = 1'b0;
        imm_type      = IMM_I;
        instr_retired = 1'b0;

        // Outputs are gated by rst_n itself so that a reset asserted in the
        // middle of a cycle drops any request immediately, not at the next edge.
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_we   = 1'b1;
                        state_d = S_DECODE;
                    end
                end

                S_DECODE: begin
                    op_d     = opcode;
                    imm_type = imm_type_of(opcode);
                    if (is_legal(opcode)) begin
                        state_d = S_EXECUTE;
                    end else begin
                        illegal_d = 1'b1;
                        if (RESET_TRAP) begin
                            state_d = S_TRAP;
                        end else begin
                            // Skip the instruction: advance PC, nothing retires.
                            pc_we   = 1'b1;
                            pc_sel  = 1'b0;
                            state_d = S_FETCH;
                        end
                    end
                end

                S_EXECUTE: begin
                    imm_type    = imm_type_of(op_q);
                    alu_src_imm = uses_imm(op_q);
                    case (op_q)
                        OP_BRANCH: begin
                            pc_we         = 1'b1;
                            pc_sel        = branch_taken;
                            instr_retired = 1'b1;
                            state_d       = S_FETCH;
                        end
                        OP_JAL: begin
                            // Link write and jump happen together in one cycle.
                            reg_we        = 1'b1;
                            wb_sel        = WB_PC4;
                            pc_we         = 1'b1;
                            pc_sel        = 1'b1;
                            instr_retired = 1'b1;
                            state_d       = S_FETCH;
                        end
                        OP_LOAD, OP_STORE: state_d = S_MEM;
                        default:           state_d = S_WB;
                    endcase
                end

                S_MEM: begin
                    // Address operands stay selected for the whole access.
                    dmem_req    = 1'b1;
                    dmem_we     = (op_q == OP_STORE);
                    imm_type    = imm_type_of(op_q);
                    alu_src_imm = uses_imm(op_q);
                    if (dmem_ready) begin
                        if (op_q == OP_STORE) begin
                            pc_we         = 1'b1;
                            pc_sel        = 1'b0;
                            instr_retired = 1'b1;
                            state_d       = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                end

                S_WB: begin
                    // Selects are held so the writeback value stays stable.
                    reg_we        = 1'b1;
                    wb_sel        = wb_sel_of(op_q);
                    imm_type      = imm_type_of(op_q);
                    alu_src_imm   = uses_imm(op_q);
                    pc_we         = 1'b1;
                    pc_sel        = 1'b0;
                    instr_retired = 1'b1;
                    state_d       = S_FETCH;
                end

                S_TRAP: begin
                    state_d = S_TRAP;
                end

                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    assign illegal   = illegal_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_rv_multicycle_control.sv
module tb_rv_multicycle_control;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n, rst1_n;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       imem_ready, imem_ready1, dmem_ready;

    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we;
    logic [1:0] wb_sel;
    logic       alu_src_imm, illegal, instr_retired;
    logic [2:0] imm_type, state_dbg;

    logic       imem_req1, dmem_req1, dmem_we1, ir_we1, pc_we1, pc_sel1, reg_we1;
    logic [1:0] wb_sel1;
    logic       alu_src_imm1, illegal1, instr_retired1;
    logic [2:0] imm_type1, state_dbg1;

    always #5 clk = ~clk;

    rv_multicycle_control #(.RESET_TRAP(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .imem_req(imem_req), .imem_ready(imem_ready), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_ready(dmem_ready), .ir_we(ir_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel), .alu_src_imm(alu_src_imm),
        .imm_type(imm_type), .illegal(illegal), .instr_retired(instr_retired),
        .state_dbg(state_dbg)
    );

    rv_multicycle_control #(.RESET_TRAP(1'b1)) dut_trap (
        .clk(clk), .rst_n(rst1_n), .opcode(opcode), .branch_taken(branch_taken),
        .imem_req(imem_req1), .imem_ready(imem_ready1), .dmem_req(dmem_req1),
        .dmem_we(dmem_we1), .dmem_ready(dmem_ready), .ir_we(ir_we1), .pc_we(pc_we1),
        .pc_sel(pc_sel1), .reg_we(reg_we1), .wb_sel(wb_sel1), .alu_src_imm(alu_src_imm1),
        .imm_type(imm_type1), .illegal(illegal1), .instr_retired(instr_retired1),
        .state_dbg(state_dbg1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         lat;
        logic       pc_sel;
        logic [1:0] wb_sel;
        int         nreg;
        int         nret;
    } exp_t;

    exp_t sb_q[$];

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req, ir_we, dmem_req, dmem_we, reg_we;
        logic [1:0] wb_sel;
        logic       pc_we, pc_sel, alu_src_imm;
        logic [2:0] imm_type;
        logic       illegal, retired;
    } smp_t;

    smp_t tr [64];
    int   tr_len;

    // Reference model of one instruction's observable retirement.
    function automatic exp_t model(input logic [6:0] op, input int iw, input int dw, input logic bt);
        exp_t e;
        e.pc_sel = 1'b0; e.wb_sel = 2'd0; e.nreg = 1; e.nret = 1; e.lat = 4;
        case (op)
            OP_R, OP_I: e.lat = 4;
            OP_LUI:     begin e.lat = 4; e.wb_sel = 2'd3; end
            OP_LOAD:    begin e.lat = 5 + dw; e.wb_sel = 2'd1; end
            OP_STORE:   begin e.lat = 4 + dw; e.nreg = 0; end
            OP_BRANCH:  begin e.lat = 3; e.nreg = 0; e.pc_sel = bt; end
            OP_JAL:     begin e.lat = 3; e.wb_sel = 2'd2; e.pc_sel = 1'b1; end
            default:    begin e.lat = 2; e.nreg = 0; e.nret = 0; end
        endcase
        e.lat += iw;
        return e;
    endfunction

    // Scoreboard: pops one expectation for every PC update of the main DUT.
    initial begin
        int   ccount = 0, acc_reg = 0, acc_ret = 0, acc_ir = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ccount = 0; acc_reg = 0; acc_ret = 0; acc_ir = 0;
            end else begin
                ccount++;
                acc_reg += int'(reg_we);
                acc_ret += int'(instr_retired);
                acc_ir  += int'(ir_we);
                n_tests++;
                if (int'(ir_we) + int'(reg_we) + int'(dmem_req) > 1) begin
                    n_fail++;
                    $display("FAIL strobe_exclusive: ir_we=%b reg_we=%b dmem_req=%b, at most one allowed", ir_we, reg_we, dmem_req);
                end
                if (pc_we) begin
                    n_tests++;
                    if (sb_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected_pc_we: pc_we=1 with no instruction expected");
                    end else begin
                        e = sb_q.pop_front();
                        n_tests++;
                        if (ccount !== e.lat) begin n_fail++; $display("FAIL sb_latency: got %0d expected %0d", ccount, e.lat); end
                        n_tests++;
                        if (pc_sel !== e.pc_sel) begin n_fail++; $display("FAIL sb_pc_sel: got %b expected %b", pc_sel, e.pc_sel); end
                        n_tests++;
                        if (acc_reg !== e.nreg) begin n_fail++; $display("FAIL sb_reg_we_count: got %0d expected %0d", acc_reg, e.nreg); end
                        n_tests++;
                        if (acc_ret !== e.nret) begin n_fail++; $display("FAIL sb_retire_count: got %0d expected %0d", acc_ret, e.nret); end
                        n_tests++;
                        if (acc_ir !== 1) begin n_fail++; $display("FAIL sb_ir_we_count: got %0d expected 1", acc_ir); end
                        if (e.nreg != 0) begin
                            n_tests++;
                            if (wb_sel !== e.wb_sel) begin n_fail++; $display("FAIL sb_wb_sel: got %0d expected %0d", wb_sel, e.wb_sel); end
                        end
                    end
                    ccount = 0; acc_reg = 0; acc_ret = 0; acc_ir = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one instruction on the main DUT with a reactive memory model and
    // records every cycle into tr[]. Opcode is only correct in DECODE.
    task automatic run_instr(input logic [6:0] op, input int iw, input int dw,
                             input logic bt, input bit expect_done, input int max_cyc);
        int iw_left = iw;
        int dw_left = dw;
        bit done = 0;
        if (expect_done) sb_q.push_back(model(op, iw, dw, bt));
        tr_len = 0;
        while (!done && tr_len < max_cyc) begin
            @(posedge clk); #1;
            opcode = (state_dbg == 3'd1) ? op : ~op;
            if (imem_req) begin
                if (iw_left > 0) begin imem_ready = 1'b0; iw_left--; end
                else imem_ready = 1'b1;
            end else imem_ready = 1'($urandom_range(0, 1));
            if (dmem_req) begin
                if (dw_left > 0) begin dmem_ready = 1'b0; dw_left--; end
                else dmem_ready = 1'b1;
            end else dmem_ready = 1'($urandom_range(0, 1));
            branch_taken = (state_dbg == 3'd2) ? bt : 1'($urandom_range(0, 1));
            @(negedge clk);
            tr[tr_len].st          = state_dbg;
            tr[tr_len].imem_req    = imem_req;
            tr[tr_len].ir_we       = ir_we;
            tr[tr_len].dmem_req    = dmem_req;
            tr[tr_len].dmem_we     = dmem_we;
            tr[tr_len].reg_we      = reg_we;
            tr[tr_len].wb_sel      = wb_sel;
            tr[tr_len].pc_we       = pc_we;
            tr[tr_len].pc_sel      = pc_sel;
            tr[tr_len].alu_src_imm = alu_src_imm;
            tr[tr_len].imm_type    = imm_type;
            tr[tr_len].illegal     = illegal;
            tr[tr_len].retired     = instr_retired;
            tr_len++;
            if (pc_we) done = 1;
        end
        if (expect_done && !done) begin
            n_tests++; n_fail++;
            $display("FAIL instr_timeout: opcode %b did not complete within %0d cycles", op, max_cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst1_n = 1'b0; opcode = OP_R; branch_taken = 1'b0;
        imem_ready = 1'b1; imem_ready1 = 1'b0; dmem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_imem_req: got %b expected 0", imem_req); end
        n_tests++;
        if ({ir_we, pc_we, reg_we, dmem_req, instr_retired} !== 5'b0) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 00000", {ir_we, pc_we, reg_we, dmem_req, instr_retired});
        end
        n_tests++;
        if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
        n_tests++;
        if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
        imem_ready = 1'b0; dmem_ready = 1'b0;
        #1 rst_n = 1'b1;
        #1;
        n_tests++;
        if (imem_req !== 1'b1) begin n_fail++; $display("FAIL release_imem_req: got %b expected 1", imem_req); end
    endtask

    task automatic test_r_type();
        logic [2:0] exp_st [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
        run_instr(OP_R, 0, 0, 1'b0, 1'b1, 20);
        n_tests++;
        if (tr_len !== 4) begin n_fail++; $display("FAIL r_latency: got %0d expected 4", tr_len); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (tr[i].st !== exp_st[i]) begin n_fail++; $display("FAIL r_state%0d: got %0d expected %0d", i, tr[i].st, exp_st[i]); end
        end
        n_tests++;
        if (tr[0].ir_we !== 1'b1) begin n_fail++; $display("FAIL r_ir_we: got %b expected 1", tr[0].ir_we); end
        n_tests++;
        if (tr[2].alu_src_imm !== 1'b0) begin n_fail++; $display("FAIL r_alu_src: got %b expected 0", tr[2].alu_src_imm); end
        n_tests++;
        if ({tr[3].reg_we, tr[3].pc_we, tr[3].retired, tr[3].wb_sel} !== 5'b11100) begin
            n_fail++; $display("FAIL r_wb_cycle: got %b expected 11100", {tr[3].reg_we, tr[3].pc_we, tr[3].retired, tr[3].wb_sel});
        end
    endtask

    task automatic test_load_wait();
        int n_req = 0;
        run_instr(OP_LOAD, 0, 3, 1'b0, 1'b1, 30);
        n_tests++;
        if (tr_len !== 8) begin n_fail++; $display("FAIL load_latency: got %0d expected 8", tr_len); end
        for (int i = 0; i < tr_len; i++) begin
            if (tr[i].dmem_req) begin
                n_req++;
                n_tests++;
                if ({tr[i].dmem_we, tr[i].alu_src_imm, tr[i].imm_type} !== 5'b01000) begin
                    n_fail++; $display("FAIL load_mem_hold: got %b expected 01000", {tr[i].dmem_we, tr[i].alu_src_imm, tr[i].imm_type});
                end
            end
        end
        n_tests++;
        if (n_req !== 4) begin n_fail++; $display("FAIL load_dmem_req_cycles: got %0d expected 4", n_req); end
        n_tests++;
        if ({tr[7].st, tr[7].reg_we, tr[7].wb_sel} !== {3'd4, 1'b1, 2'd1}) begin
            n_fail++; $display("FAIL load_wb: got st=%0d reg_we=%b wb_sel=%0d expected 4 1 1", tr[7].st, tr[7].reg_we, tr[7].wb_sel);
        end
    endtask

    task automatic test_store_branch();
        run_instr(OP_STORE, 0, 1, 1'b0, 1'b1, 20);
        n_tests++;
        if (tr_len !== 5) begin n_fail++; $display("FAIL store_latency: got %0d expected 5", tr_len); end
        n_tests++;
        if (tr[1].imm_type !== 3'd1) begin n_fail++; $display("FAIL store_decode_imm: got %0d expected 1", tr[1].imm_type); end
        n_tests++;
        if ({tr[3].dmem_req, tr[3].dmem_we, tr[4].dmem_req, tr[4].dmem_we} !== 4'b1111) begin
            n_fail++; $display("FAIL store_dmem_we: got %b expected 1111", {tr[3].dmem_req, tr[3].dmem_we, tr[4].dmem_req, tr[4].dmem_we});
        end
        for (int i = 0; i < tr_len; i++) begin
            n_tests++;
            if (tr[i].reg_we !== 1'b0) begin n_fail++; $display("FAIL store_reg_we%0d: got %b expected 0", i, tr[i].reg_we); end
        end
        for (int k = 0; k < 2; k++) begin
            logic bt;
            bt = (k == 0);
            run_instr(OP_BRANCH, 0, 0, bt, 1'b1, 20);
            n_tests++;
            if (tr_len !== 3) begin n_fail++; $display("FAIL branch%0d_latency: got %0d expected 3", k, tr_len); end
            n_tests++;
            if ({tr[2].pc_we, tr[2].pc_sel, tr[2].retired, tr[2].imm_type} !== {1'b1, bt, 1'b1, 3'd2}) begin
                n_fail++; $display("FAIL branch%0d_execute: got %b expected %b", k,
                    {tr[2].pc_we, tr[2].pc_sel, tr[2].retired, tr[2].imm_type}, {1'b1, bt, 1'b1, 3'd2});
            end
        end
    endtask

    task automatic test_jal_itype_lui();
        run_instr(OP_JAL, 2, 0, 1'b0, 1'b1, 20);
        n_tests++;
        if (tr_len !== 5) begin n_fail++; $display("FAIL jal_latency: got %0d expected 5", tr_len); end
        n_tests++;
        if ({tr[4].st, tr[4].reg_we, tr[4].wb_sel, tr[4].pc_we, tr[4].pc_sel, tr[4].imm_type} !== {3'd2, 1'b1, 2'd2, 1'b1, 1'b1, 3'd4}) begin
            n_fail++; $display("FAIL jal_execute: got %b expected %b",
                {tr[4].st, tr[4].reg_we, tr[4].wb_sel, tr[4].pc_we, tr[4].pc_sel, tr[4].imm_type}, {3'd2, 1'b1, 2'd2, 1'b1, 1'b1, 3'd4});
        end
        run_instr(OP_I, 0, 0, 1'b0, 1'b1, 20);
        n_tests++;
        if ({tr[0].st, tr[0].imem_req} !== {3'd0, 1'b1}) begin
            n_fail++; $display("FAIL jal_next_fetch: got st=%0d imem_req=%b expected 0 1", tr[0].st, tr[0].imem_req);
        end
        n_tests++;
        if ({tr[2].alu_src_imm, tr[2].imm_type} !== 4'b1000) begin
            n_fail++; $display("FAIL itype_execute: got %b expected 1000", {tr[2].alu_src_imm, tr[2].imm_type});
        end
        run_instr(OP_LUI, 1, 0, 1'b0, 1'b1, 20);
        n_tests++;
        if ({tr[3].imm_type, tr[4].wb_sel} !== {3'd3, 2'd3}) begin
            n_fail++; $display("FAIL lui: got imm_type=%0d wb_sel=%0d expected 3 3", tr[3].imm_type, tr[4].wb_sel);
        end
    endtask

    task automatic test_illegal_skip();
        run_instr(OP_BAD, 1, 0, 1'b0, 1'b1, 20);
        n_tests++;
        if (tr_len !== 3) begin n_fail++; $display("FAIL illegal_latency: got %0d expected 3", tr_len); end
        n_tests++;
        if ({tr[2].st, tr[2].pc_we, tr[2].pc_sel, tr[2].retired, tr[2].reg_we} !== {3'd1, 4'b1000}) begin
            n_fail++; $display("FAIL illegal_skip: got %b expected %b",
                {tr[2].st, tr[2].pc_we, tr[2].pc_sel, tr[2].retired, tr[2].reg_we}, {3'd1, 4'b1000});
        end
        run_instr(OP_R, 0, 0, 1'b0, 1'b1, 20);
        n_tests++;
        if ({tr[0].illegal, tr[3].illegal} !== 2'b11) begin
            n_fail++; $display("FAIL illegal_sticky: got %b expected 11", {tr[0].illegal, tr[3].illegal});
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [7] = '{OP_R, OP_I, OP_LUI, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL};
        for (int n = 0; n < 24; n++) begin
            run_instr(ops[$urandom_range(0, 6)], $urandom_range(0, 2), $urandom_range(0, 2),
                      1'($urandom_range(0, 1)), 1'b1, 30);
        end
        n_tests++;
        if (illegal !== 1'b1) begin n_fail++; $display("FAIL b2b_illegal_sticky: got %b expected 1", illegal); end
    endtask

    task automatic test_reset_mid_mem();
        run_instr(OP_STORE, 0, 100, 1'b0, 1'b0, 5);
        n_tests++;
        if ({tr[4].st, tr[4].dmem_req} !== {3'd3, 1'b1}) begin
            n_fail++; $display("FAIL midmem_setup: got st=%0d dmem_req=%b expected 3 1", tr[4].st, tr[4].dmem_req);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({dmem_req, dmem_we, pc_we, reg_we, instr_retired} !== 5'b0) begin
            n_fail++; $display("FAIL midmem_drop: got %b expected 00000", {dmem_req, dmem_we, pc_we, reg_we, instr_retired});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        n_tests++;
        if ({state_dbg, illegal, imem_req} !== {3'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL midmem_restart: got st=%0d illegal=%b imem_req=%b expected 0 0 1", state_dbg, illegal, imem_req);
        end
        run_instr(OP_R, 0, 0, 1'b0, 1'b1, 20);
        n_tests++;
        if (tr_len !== 4) begin n_fail++; $display("FAIL midmem_next_instr: got %0d expected 4", tr_len); end
    endtask

    task automatic test_trap();
        imem_ready = 1'b0;
        #1 rst1_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            opcode       = (i < 6) ? OP_BAD : OP_R;
            imem_ready1  = 1'b1;
            dmem_ready   = 1'($urandom_range(0, 1));
            branch_taken = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (i == 0) begin
                n_tests++;
                if ({state_dbg1, ir_we1} !== {3'd0, 1'b1}) begin
                    n_fail++; $display("FAIL trap_fetch: got st=%0d ir_we=%b expected 0 1", state_dbg1, ir_we1);
                end
            end else if (i == 1) begin
                n_tests++;
                if ({state_dbg1, pc_we1} !== {3'd1, 1'b0}) begin
                    n_fail++; $display("FAIL trap_decode: got st=%0d pc_we=%b expected 1 0", state_dbg1, pc_we1);
                end
            end else begin
                n_tests++;
                if ({state_dbg1, illegal1} !== {3'd5, 1'b1}) begin
                    n_fail++; $display("FAIL trap_state%0d: got st=%0d illegal=%b expected 5 1", i, state_dbg1, illegal1);
                end
                n_tests++;
                if ({imem_req1, ir_we1, dmem_req1, pc_we1, reg_we1, instr_retired1} !== 6'b0) begin
                    n_fail++; $display("FAIL trap_strobes%0d: got %b expected 000000", i,
                        {imem_req1, ir_we1, dmem_req1, pc_we1, reg_we1, instr_retired1});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_load_wait();
        test_store_branch();
        test_jal_itype_lui();
        test_illegal_skip();
        test_back_to_back();
        test_reset_mid_mem();
        test_trap();
        n_tests++;
        if (sb_q.size() !== 0) begin n_fail++; $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
